noc_rr_arbiter: RTL and testbench

- Parametrised N-way round-robin arbiter with packet locking for NoC output ports.
- Generalises the combinational one-hot/priority-to-binary encoder into a registered block:
  - rotating priority;
  - grant held for a whole packet;
  - both one-hot and binary grant outputs.
- Sits between the N input-port request lines of a router and the crossbar select of one output port.

---
 rtl/noc_rr_arbiter.sv | 112 +++++++++++
 tb/tb_noc_rr_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/noc_rr_arbiter.sv
// Round-robin arbiter for one NoC output port: rotating priority, grant locked for a
// whole packet, with registered one-hot and binary grant outputs.
module noc_rr_arbiter #(
  parameter int N = 4,
  parameter int M = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  input  logic         out_last,
  output logic [N-1:0] gnt,
  output logic [M-1:0] gnt_idx,
  output logic         gnt_valid
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t       state, state_nxt;
  logic [M-1:0] ptr, ptr_nxt;
  logic [N-1:0] gnt_nxt;
  logic [M-1:0] idx_nxt;
  logic         valid_nxt;

  logic         pick_found;
  logic [M-1:0] pick_idx;
  logic [N-1:0] pick_gnt;
  logic [N-1:0] probe;
  int           cand;
  logic         release_pkt;

  assign release_pkt = out_ready && out_last;

  // Rotating search from ptr; candidates wrap at N-1, so codes >= N never appear.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_gnt   = '0;
    probe      = '0;
    cand       = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      probe = N'(1) << cand;
      if (!pick_found && ((req & probe) != '0)) begin
        pick_found = 1'b1;
        pick_idx   = M'(cand);
        pick_gnt   = probe;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt       <= gnt_nxt;
      gnt_idx   <= idx_nxt;
      gnt_valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = LOCKED;
      LOCKED:  if (release_pkt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered output values; requests are ignored entirely while a packet is locked.
  always_comb begin
    gnt_nxt   = gnt;
    idx_nxt   = gnt_idx;
    valid_nxt = gnt_valid;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (pick_found) begin
          gnt_nxt   = pick_gnt;
          idx_nxt   = pick_idx;
          valid_nxt = 1'b1;
        end else begin
          gnt_nxt   = '0;
          idx_nxt   = '0;
          valid_nxt = 1'b0;
        end
      end
      LOCKED: begin
        if (release_pkt) begin
          gnt_nxt   = '0;
          idx_nxt   = '0;
          valid_nxt = 1'b0;
          ptr_nxt   = (gnt_idx == M'(N - 1)) ? '0 : gnt_idx + M'(1);
        end
      end
      default: begin
        gnt_nxt   = '0;
        idx_nxt   = '0;
        valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Scoreboard bench for noc_rr_arbiter: a 4-way instance (directed, then random) and a
// 5-way instance (random throughout), both checked against a packet-level reference model.
module tb_noc_rr_arbiter;

  localparam int N0 = 4, M0 = 2, N1 = 5, M1 = 3;

  logic clk = 1'b0;
  logic rst;

  logic [N0-1:0] req0;
  logic          ready0, last0;
  logic [N0-1:0] gnt0;
  logic [M0-1:0] idx0;
  logic          valid0;

  logic [N1-1:0] req1;
  logic          ready1, last1;
  logic [N1-1:0] gnt1;
  logic [M1-1:0] idx1;
  logic          valid1;

  always #5 clk = ~clk;

  noc_rr_arbiter #(.N(N0), .M(M0)) u_arb4 (
    .clk(clk), .rst(rst), .req(req0), .out_ready(ready0), .out_last(last0),
    .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(valid0)
  );

  noc_rr_arbiter #(.N(N1), .M(M1)) u_arb5 (
    .clk(clk), .rst(rst), .req(req1), .out_ready(ready1), .out_last(last1),
    .gnt(gnt1), .gnt_idx(idx1), .gnt_valid(valid1)
  );

  typedef struct {
    int unit;
    int gnt;
    int idx;
    int valid;
    int req;
    bit rst;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  int unit_n[2] = '{N0, N1};
  int m_locked[2];
  int m_owner[2];
  int m_ptr[2];

  // Packet-level model: who owns the port, and where the rotating priority starts.
  function automatic void modelStep(int u, bit r, int rq, bit rdy, bit lst);
    int n, c;
    exp_t e;
    n = unit_n[u];
    if (r) begin
      m_locked[u] = 0;
      m_owner[u]  = 0;
      m_ptr[u]    = 0;
    end else if (m_locked[u] == 0) begin
      for (int k = 0; k < n; k++) begin
        c = (m_ptr[u] + k) % n;
        if (m_locked[u] == 0 && ((rq >> c) & 1) == 1) begin
          m_owner[u]  = c;
          m_locked[u] = 1;
        end
      end
    end else if (rdy && lst) begin
      m_ptr[u]    = (m_owner[u] + 1) % n;
      m_locked[u] = 0;
    end
    e.unit  = u;
    e.gnt   = (m_locked[u] != 0) ? (1 << m_owner[u]) : 0;
    e.idx   = (m_locked[u] != 0) ? m_owner[u] : 0;
    e.valid = m_locked[u];
    e.req   = rq;
    e.rst   = r;
    sb.push_back(e);
  endfunction

  function automatic int dutGnt(int u);
    return (u == 0) ? int'(gnt0) : int'(gnt1);
  endfunction

  function automatic int dutIdx(int u);
    return (u == 0) ? int'(idx0) : int'(idx1);
  endfunction

  function automatic int dutValid(int u);
    return (u == 0) ? int'(valid0) : int'(valid1);
  endfunction

  function automatic int idxOfOneHot(int g);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++) if (((g >> i) & 1) == 1) r = i;
    return r;
  endfunction

  task automatic checkOutput(string name, int u, int got, int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("[TB] FAIL u%0d %s: got %0d expected %0d at %0t", u, name, got, exp, $time);
    end
  endtask

  task automatic checkBound(string name, int u, int got, int limit);
    vectors++;
    if (got > limit) begin
      miscompares++;
      $display("[TB] FAIL u%0d %s: got %0d expected at most %0d at %0t", u, name, got, limit, $time);
    end
  endtask

  task automatic applyStimulus(bit r, int rq0, bit rd0, bit ls0, int rq1, bit rd1, bit ls1);
    @(negedge clk);
    rst    = r;
    req0   = N0'(rq0);
    ready0 = rd0;
    last0  = ls0;
    req1   = N1'(rq1);
    ready1 = rd1;
    last1  = ls1;
    modelStep(0, r, rq0 & ((1 << N0) - 1), rd0, ls0);
    modelStep(1, r, rq1 & ((1 << N1) - 1), rd1, ls1);
  endtask

  task automatic step0(bit r, int rq0, bit rd0, bit ls0);
    applyStimulus(r, rq0, rd0, ls0,
                  int'($urandom_range(0, (1 << N1) - 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0));
  endtask

  // Monitor: pops every expectation queued for the edge just taken and checks the DUTs.
  bit prev_valid[2];
  int waitc[2][8];

  initial begin
    exp_t e;
    int   g, owner;
    prev_valid[0] = 0;
    prev_valid[1] = 0;
    for (int u = 0; u < 2; u++) for (int i = 0; i < 8; i++) waitc[u][i] = 0;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        g = dutGnt(e.unit);
        checkOutput("gnt", e.unit, g, e.gnt);
        checkOutput("gnt_idx", e.unit, dutIdx(e.unit), e.idx);
        checkOutput("gnt_valid", e.unit, dutValid(e.unit), e.valid);
        checkBound("gnt_bits_set", e.unit, $countones(g), 1);
        checkOutput("idx_vs_gnt", e.unit, dutIdx(e.unit), idxOfOneHot(g));
        checkOutput("valid_vs_gnt", e.unit, dutValid(e.unit), int'(g != 0));
        if (e.rst) begin
          for (int i = 0; i < 8; i++) waitc[e.unit][i] = 0;
        end else if (dutValid(e.unit) == 1 && !prev_valid[e.unit]) begin
          owner = dutIdx(e.unit);
          for (int i = 0; i < unit_n[e.unit]; i++) begin
            if (i == owner) waitc[e.unit][i] = 0;
            else if (((e.req >> i) & 1) == 1) waitc[e.unit][i]++;
            else waitc[e.unit][i] = 0;
            checkBound("fair_wait", e.unit, waitc[e.unit][i], unit_n[e.unit] - 1);
          end
        end
        prev_valid[e.unit] = (dutValid(e.unit) == 1);
      end
    end
  end

  initial begin
    rst = 1'b1;
    req0 = '0; ready0 = 1'b0; last0 = 1'b0;
    req1 = '0; ready1 = 1'b0; last1 = 1'b0;
    for (int u = 0; u < 2; u++) begin
      m_locked[u] = 0; m_owner[u] = 0; m_ptr[u] = 0;
    end

    repeat (3) step0(1'b1, 0, 1'b0, 1'b0);
    repeat (5) step0(1'b0, 4'b0000, 1'b0, 1'b0);
    step0(1'b0, 4'b0000, 1'b1, 1'b1);

    repeat (3) step0(1'b0, 4'b1010, 1'b0, 1'b0);
    step0(1'b0, 4'b1010, 1'b1, 1'b1);
    repeat (3) step0(1'b0, 4'b1010, 1'b0, 1'b0);
    step0(1'b0, 4'b1010, 1'b1, 1'b1);
    repeat (2) step0(1'b0, 4'b1010, 1'b0, 1'b0);
    step0(1'b0, 4'b1010, 1'b1, 1'b1);

    step0(1'b0, 4'b0100, 1'b0, 1'b0);
    repeat (2) step0(1'b0, 4'b0001, 1'b0, 1'b0);
    repeat (3) step0(1'b0, 4'b0001, 1'b0, 1'b1);
    step0(1'b0, 4'b0001, 1'b1, 1'b1);

    step0(1'b0, 4'b1000, 1'b0, 1'b0);
    repeat (2) step0(1'b0, 4'b1000, 1'b0, 1'b0);

    // Mid-packet reset must clear the outputs without waiting for an edge.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_gnt", 0, int'(gnt0), 0);
    checkOutput("async_rst_idx", 0, int'(idx0), 0);
    checkOutput("async_rst_valid", 0, int'(valid0), 0);
    checkOutput("async_rst_valid", 1, int'(valid1), 0);

    repeat (2) step0(1'b1, 4'b1111, 1'b0, 1'b0);
    repeat (2) step0(1'b0, 4'b1111, 1'b0, 1'b0);
    step0(1'b0, 4'b1111, 1'b1, 1'b1);
    repeat (8) step0(1'b0, 4'b1111, 1'b1, 1'b1);

    repeat (10000)
      applyStimulus(1'b0,
                    int'($urandom_range(0, (1 << N0) - 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0),
                    int'($urandom_range(0, (1 << N1) - 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0));

    @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
